// File: rtl/ft245_sync_fifo_if.sv
// FPGA-side master for the FT232H in FT245 synchronous FIFO mode.
// Arbitrates the shared 8-bit bus between host->FPGA reads (RX) and FPGA->host writes (TX).
// Exposes valid/ready byte streams on both sides. Runs entirely in the ft_clkout domain;
// the ft_bus tristate buffer lives in the enclosing top level.
//
// Ports:
//   clk_in, rst_n             clock (ft_clkout) and asynchronous active-low reset
//   ft_data_in/out, ft_data_oe bus sample, bus drive value, bus drive enable
//   ft_rxf_n, ft_txe_n         FT232H has data / can accept data (active low)
//   ft_oe_n, ft_rd_n, ft_wr_n  FT232H output enable, read and write strobes (active low)
//   ft_siwu_n                  send-immediate pulse (active low)
//   rx_data/valid/ready        received byte stream (first-word-fall-through)
//   tx_data/valid/ready        byte stream to send
module ft245_sync_fifo_if #(
    parameter int unsigned RX_DEPTH  = 4,
    parameter int unsigned TX_DEPTH  = 4,
    parameter int unsigned MAX_BURST = 64,
    parameter bit          SIWU_EN   = 1'b1
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [7:0] ft_data_in,
    output logic [7:0] ft_data_out,
    output logic       ft_data_oe,
    input  logic       ft_rxf_n,
    input  logic       ft_txe_n,
    output logic       ft_oe_n,
    output logic       ft_rd_n,
    output logic       ft_wr_n,
    output logic       ft_siwu_n,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);

    localparam int unsigned RxAw   = $clog2(RX_DEPTH);
    localparam int unsigned TxAw   = $clog2(TX_DEPTH);
    localparam int unsigned BurstW = $clog2(MAX_BURST + 1);

    localparam logic [RxAw:0]     RxFull   = (RxAw + 1)'(RX_DEPTH);
    localparam logic [TxAw:0]     TxFull   = (TxAw + 1)'(TX_DEPTH);
    localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST);

    typedef enum logic [2:0] {
        StIdle,
        StRxOe,
        StRxRead,
        StTxWrite,
        StTurn
    } state_e;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [7:0]      rx_mem_q [RX_DEPTH];
    logic [RxAw-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RxAw:0]   rx_count_q, rx_count_d;
    logic            rx_push, rx_pop;

    logic [7:0]      tx_mem_q [TX_DEPTH];
    logic [TxAw-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d, tx_rptr_nxt;
    logic [TxAw:0]   tx_count_q, tx_count_d;
    logic            tx_push, tx_pop;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic              last_rx_q, last_rx_d;  // 1 = RX was the last direction served
    logic [BurstW-1:0] burst_q, burst_d, burst_inc;
    logic              oe_n_q, oe_n_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              siwu_n_q, siwu_n_d;
    logic              data_oe_q, data_oe_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              rx_elig, tx_elig;

    // Every edge spent in RX_READ / TX_WRITE with the flag asserted moves one byte.
    assign rx_push = (state_q == StRxRead) && !ft_rxf_n;
    assign tx_pop  = (state_q == StTxWrite) && !ft_txe_n;
    assign rx_pop  = rx_valid && rx_ready;
    assign tx_push = tx_valid && tx_ready;

    assign rx_valid    = (rx_count_q != '0);
    assign rx_data     = rx_mem_q[rx_rptr_q];
    assign tx_ready    = (tx_count_q < TxFull);
    assign tx_rptr_nxt = tx_rptr_q + TxAw'(1);
    assign burst_inc   = burst_q + BurstW'(1);

    assign rx_elig = !ft_rxf_n && (rx_count_q < RxFull);
    assign tx_elig = (tx_count_q != '0) && !ft_txe_n;

    always_comb begin
        rx_wptr_d  = rx_push ? rx_wptr_q + RxAw'(1) : rx_wptr_q;
        rx_rptr_d  = rx_pop ? rx_rptr_q + RxAw'(1) : rx_rptr_q;
        rx_count_d = rx_count_q;
        if (rx_push && !rx_pop) begin
            rx_count_d = rx_count_q + (RxAw + 1)'(1);
        end else if (!rx_push && rx_pop) begin
            rx_count_d = rx_count_q - (RxAw + 1)'(1);
        end
    end

    always_comb begin
        tx_wptr_d  = tx_push ? tx_wptr_q + TxAw'(1) : tx_wptr_q;
        tx_rptr_d  = tx_pop ? tx_rptr_nxt : tx_rptr_q;
        tx_count_d = tx_count_q;
        if (tx_push && !tx_pop) begin
            tx_count_d = tx_count_q + (TxAw + 1)'(1);
        end else if (!tx_push && tx_pop) begin
            tx_count_d = tx_count_q - (TxAw + 1)'(1);
        end
    end

    // ------------------------------------------------------------------
    // Bus FSM: next state and registered FT-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        last_rx_d  = last_rx_q;
        burst_d    = burst_q;
        oe_n_d     = oe_n_q;
        rd_n_d     = rd_n_q;
        wr_n_d     = wr_n_q;
        siwu_n_d   = 1'b1;
        data_oe_d  = data_oe_q;
        data_out_d = data_out_q;

        unique case (state_q)
            StIdle: begin
                // On a tie, serve the direction that was not served last.
                if (rx_elig && (!tx_elig || !last_rx_q)) begin
                    oe_n_d  = 1'b0;
                    state_d = StRxOe;
                end else if (tx_elig) begin
                    data_oe_d  = 1'b1;
                    data_out_d = tx_mem_q[tx_rptr_q];
                    wr_n_d     = 1'b0;
                    last_rx_d  = 1'b0;
                    state_d    = StTxWrite;
                end
            end

            StRxOe: begin
                rd_n_d    = 1'b0;
                last_rx_d = 1'b1;
                state_d   = StRxRead;
            end

            StRxRead: begin
                if (rx_push) begin
                    burst_d = burst_inc;
                end
                // Stop before the FIFO could overflow on the following edge.
                if (!(rx_push && (rx_count_d < RxFull) && (burst_inc < BurstMax))) begin
                    rd_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    state_d = StTurn;
                end
            end

            StTxWrite: begin
                if (tx_pop && (tx_count_q > (TxAw + 1)'(1)) && (burst_inc < BurstMax)) begin
                    burst_d    = burst_inc;
                    data_out_d = tx_mem_q[tx_rptr_nxt];
                end else begin
                    // Either the last byte went out, the burst cap was hit, or the
                    // FT232H refused the byte and it stays at the FIFO head.
                    if (tx_pop) begin
                        burst_d = burst_inc;
                    end
                    wr_n_d    = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = StTurn;
                    if (SIWU_EN && tx_pop && (tx_count_d == '0)) begin
                        siwu_n_d = 1'b0;
                    end
                end
            end

            StTurn: begin
                oe_n_d    = 1'b1;
                rd_n_d    = 1'b1;
                wr_n_d    = 1'b1;
                data_oe_d = 1'b0;
                burst_d   = '0;
                state_d   = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_rx_q  <= 1'b0;
            burst_q    <= '0;
            oe_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            siwu_n_q   <= 1'b1;
            data_oe_q  <= 1'b0;
            data_out_q <= 8'h00;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_count_q <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_count_q <= '0;
        end else begin
            state_q    <= state_d;
            last_rx_q  <= last_rx_d;
            burst_q    <= burst_d;
            oe_n_q     <= oe_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            siwu_n_q   <= siwu_n_d;
            data_oe_q  <= data_oe_d;
            data_out_q <= data_out_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_count_q <= rx_count_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_count_q <= tx_count_d;
        end
    end

    // Storage needs no reset: contents are only visible through the reset pointers.
    always_ff @(posedge clk_in) begin
        if (rx_push) begin
            rx_mem_q[rx_wptr_q] <= ft_data_in;
        end
        if (tx_push) begin
            tx_mem_q[tx_wptr_q] <= tx_data;
        end
    end

    assign ft_oe_n     = oe_n_q;
    assign ft_rd_n     = rd_n_q;
    assign ft_wr_n     = wr_n_q;
    assign ft_siwu_n   = siwu_n_q;
    assign ft_data_oe  = data_oe_q;
    assign ft_data_out = data_out_q;

endmodule

// File: tb/tb_ft245_sync_fifo_if.sv
// Self-checking bench for ft245_sync_fifo_if: a cycle-by-cycle vector table for the basic
// RX and TX bursts, followed by hand-written sequences with a small FT232H host model for
// backpressure, TX stall, arbitration and asynchronous reset.
module tb_ft245_sync_fifo_if;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b1;
    logic [7:0] ft_data_in = 8'h00;
    logic [7:0] ft_data_out;
    logic       ft_data_oe;
    logic       ft_rxf_n = 1'b1;
    logic       ft_txe_n = 1'b1;
    logic       ft_oe_n, ft_rd_n, ft_wr_n, ft_siwu_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;

    ft245_sync_fifo_if dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .ft_data_in  (ft_data_in),
        .ft_data_out (ft_data_out),
        .ft_data_oe  (ft_data_oe),
        .ft_rxf_n    (ft_rxf_n),
        .ft_txe_n    (ft_txe_n),
        .ft_oe_n     (ft_oe_n),
        .ft_rd_n     (ft_rd_n),
        .ft_wr_n     (ft_wr_n),
        .ft_siwu_n   (ft_siwu_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    always #5 clk_in = ~clk_in;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // {oe_n, rd_n, wr_n, siwu_n, data_oe, data_out, rx_valid, tx_ready}
    function automatic logic [13:0] outs();
        return {ft_oe_n, ft_rd_n, ft_wr_n, ft_siwu_n, ft_data_oe, ft_data_out, rx_valid, tx_ready};
    endfunction
    localparam logic [13:0] ResetExp = {4'b1111, 1'b0, 8'h00, 1'b0, 1'b1};

    // ------------------------------------------------------------------
    // Vector table: inputs applied before an edge, outputs checked 1 after it.
    // e_flags = {oe_n, rd_n, wr_n, siwu_n, data_oe, rx_valid, tx_ready}
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       rxf_n;
        logic       txe_n;
        logic [7:0] din;
        logic       tx_valid;
        logic [7:0] tx_data;
        logic       rx_ready;
        logic [6:0] e_flags;
        logic [7:0] e_dout;
        logic [7:0] e_rxd;
    } vec_t;

    function automatic vec_t mk(input logic rxf, input logic txe, input logic [7:0] din,
                                input logic tv, input logic [7:0] td, input logic rr,
                                input logic [6:0] fl, input logic [7:0] dout,
                                input logic [7:0] rxd);
        vec_t v;
        v = '{rxf_n: rxf, txe_n: txe, din: din, tx_valid: tv, tx_data: td, rx_ready: rr,
              e_flags: fl, e_dout: dout, e_rxd: rxd};
        return v;
    endfunction

    localparam int NV = 22;
    vec_t tbl [NV];

    // ------------------------------------------------------------------
    // FT232H host model and logs used by the hand-written sequences
    // ------------------------------------------------------------------
    logic [7:0] host_bytes [16];
    int         host_idx = 0;
    int         host_n   = 0;
    logic [7:0] wlog [$];  // bytes accepted by the FT232H
    logic [7:0] rlog [$];  // bytes popped by the consumer
    logic [7:0] blog [$];  // burst starts: 'R' or 'W'
    int         siwu_cnt = 0;

    task automatic cycle();
        logic took, wrote, popped, oe_prev, wr_prev;
        logic [7:0] dout, rxd;
        ft_rxf_n   = (host_idx < host_n) ? 1'b0 : 1'b1;
        ft_data_in = (host_idx < host_n) ? host_bytes[host_idx] : 8'h00;
        took    = !ft_rd_n && !ft_rxf_n;
        wrote   = !ft_wr_n && !ft_txe_n;
        popped  = rx_valid && rx_ready;
        dout    = ft_data_out;
        rxd     = rx_data;
        oe_prev = ft_oe_n;
        wr_prev = ft_wr_n;
        @(posedge clk_in);
        #1;
        if (took) host_idx++;
        if (wrote) wlog.push_back(dout);
        if (popped) rlog.push_back(rxd);
        if (oe_prev && !ft_oe_n) blog.push_back(8'h52);
        if (wr_prev && !ft_wr_n) blog.push_back(8'h57);
        if (!ft_siwu_n) siwu_cnt++;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        cycle();
        tx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        ft_txe_n = 1'b1;
        ft_rxf_n = 1'b1;
        host_n   = 0;
        host_idx = 0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [29:0] act, exp;
        logic [7:0]  exp_w [6];
        logic [7:0]  exp_b [4];
        logic        hit;

        tbl[0]  = mk(0, 1, 8'hA5, 0, 8'h00, 1, 7'b0111001, 8'h00, 8'h00);
        tbl[1]  = mk(0, 1, 8'hA5, 0, 8'h00, 1, 7'b0011001, 8'h00, 8'h00);
        tbl[2]  = mk(0, 1, 8'hA5, 0, 8'h00, 1, 7'b0011011, 8'h00, 8'hA5);
        tbl[3]  = mk(0, 1, 8'h5A, 0, 8'h00, 1, 7'b0011011, 8'h00, 8'h5A);
        tbl[4]  = mk(0, 1, 8'h3C, 0, 8'h00, 1, 7'b0011011, 8'h00, 8'h3C);
        tbl[5]  = mk(1, 1, 8'h00, 0, 8'h00, 1, 7'b1111001, 8'h00, 8'h00);
        tbl[6]  = mk(0, 1, 8'h00, 0, 8'h00, 1, 7'b1111001, 8'h00, 8'h00);
        tbl[7]  = mk(0, 1, 8'h00, 0, 8'h00, 1, 7'b0111001, 8'h00, 8'h00);
        tbl[8]  = mk(1, 1, 8'h00, 0, 8'h00, 1, 7'b0011001, 8'h00, 8'h00);
        tbl[9]  = mk(1, 1, 8'h00, 0, 8'h00, 1, 7'b1111001, 8'h00, 8'h00);
        tbl[10] = mk(1, 1, 8'h00, 0, 8'h00, 1, 7'b1111001, 8'h00, 8'h00);
        tbl[11] = mk(1, 1, 8'h00, 1, 8'h11, 1, 7'b1111001, 8'h00, 8'h00);
        tbl[12] = mk(1, 1, 8'h00, 1, 8'h22, 1, 7'b1111001, 8'h00, 8'h00);
        tbl[13] = mk(1, 1, 8'h00, 1, 8'h33, 1, 7'b1111001, 8'h00, 8'h00);
        tbl[14] = mk(1, 1, 8'h00, 1, 8'h44, 1, 7'b1111000, 8'h00, 8'h00);
        tbl[15] = mk(1, 1, 8'h00, 1, 8'h55, 1, 7'b1111000, 8'h00, 8'h00);
        tbl[16] = mk(1, 0, 8'h00, 0, 8'h00, 1, 7'b1101100, 8'h11, 8'h00);
        tbl[17] = mk(1, 0, 8'h00, 0, 8'h00, 1, 7'b1101101, 8'h22, 8'h00);
        tbl[18] = mk(1, 0, 8'h00, 0, 8'h00, 1, 7'b1101101, 8'h33, 8'h00);
        tbl[19] = mk(1, 0, 8'h00, 0, 8'h00, 1, 7'b1101101, 8'h44, 8'h00);
        tbl[20] = mk(1, 0, 8'h00, 0, 8'h00, 1, 7'b1110001, 8'h00, 8'h00);
        tbl[21] = mk(1, 0, 8'h00, 0, 8'h00, 1, 7'b1111001, 8'h00, 8'h00);

        // ---- Reset: asynchronous entry, held with random inputs, quiet after release
        #2 rst_n = 1'b0;
        #1 check("reset_async", 32'(outs()), 32'(ResetExp));
        repeat (4) begin
            @(negedge clk_in);
            ft_rxf_n   = 1'($urandom_range(0, 1));
            ft_txe_n   = 1'($urandom_range(0, 1));
            ft_data_in = 8'($urandom);
            rx_ready   = 1'($urandom_range(0, 1));
            tx_valid   = 1'($urandom_range(0, 1));
            tx_data    = 8'($urandom);
        end
        @(negedge clk_in);
        check("reset_hold", 32'(outs()), 32'(ResetExp));
        ft_rxf_n = 1'b1;
        ft_txe_n = 1'b1;
        rx_ready = 1'b1;
        tx_valid = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_in);
            #1;
            check($sformatf("idle_after_reset%0d", i),
                  {ft_oe_n, ft_rd_n, ft_wr_n, ft_siwu_n, ft_data_oe}, 5'b11110);
        end

        // ---- Table: RX burst A5 5A 3C, one-cycle TURN, short RX burst, TX fill + burst
        for (int i = 0; i < NV; i++) begin
            ft_rxf_n   = tbl[i].rxf_n;
            ft_txe_n   = tbl[i].txe_n;
            ft_data_in = tbl[i].din;
            tx_valid   = tbl[i].tx_valid;
            tx_data    = tbl[i].tx_data;
            rx_ready   = tbl[i].rx_ready;
            @(posedge clk_in);
            #1;
            act = {ft_oe_n, ft_rd_n, ft_wr_n, ft_siwu_n, ft_data_oe, rx_valid, tx_ready,
                   tbl[i].e_flags[2] ? ft_data_out : 8'h00,
                   tbl[i].e_flags[1] ? rx_data : 8'h00};
            exp = {tbl[i].e_flags, tbl[i].e_dout, tbl[i].e_rxd};
            check($sformatf("vec%0d", i), 32'(act), 32'(exp));
        end
        tx_valid = 1'b0;

        // ---- RX backpressure: 6 bytes offered, FIFO holds 4
        for (int i = 0; i < 6; i++) host_bytes[i] = 8'(i + 1);
        host_idx = 0;
        host_n   = 6;
        rx_ready = 1'b0;
        ft_txe_n = 1'b1;
        rlog.delete();
        repeat (12) cycle();
        check("bp_captured", 32'(host_idx), 32'd4);
        check("bp_head", {rx_valid, rx_data}, {1'b1, 8'h01});
        check("bp_strobes_idle", {ft_oe_n, ft_rd_n}, 2'b11);
        rx_ready = 1'b1;
        repeat (20) cycle();
        check("bp_total_read", 32'(host_idx), 32'd6);
        check("bp_rlog_size", 32'(rlog.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_rlog%0d", i), (i < rlog.size()) ? rlog[i] : 8'hxx, 8'(i + 1));
        end

        // ---- TX stall while 0x22 is presented
        wlog.delete();
        siwu_cnt = 0;
        push_tx(8'h11);
        push_tx(8'h22);
        push_tx(8'h33);
        ft_txe_n = 1'b0;
        cycle();
        cycle();
        check("stall_present", {ft_wr_n, ft_data_oe, ft_data_out}, {2'b01, 8'h22});
        ft_txe_n = 1'b1;
        cycle();
        check("stall_release", {ft_wr_n, ft_data_oe, ft_siwu_n}, 3'b101);
        ft_txe_n = 1'b0;
        repeat (10) cycle();
        check("stall_wlog_size", 32'(wlog.size()), 32'd3);
        exp_w[0] = 8'h11;
        exp_w[1] = 8'h22;
        exp_w[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_wlog%0d", i), (i < wlog.size()) ? wlog[i] : 8'hxx, exp_w[i]);
        end
        check("stall_siwu_pulses", 32'(siwu_cnt), 32'd1);

        // ---- Arbitration after reset: RX first, then TX, then RX again on a tie
        do_reset();
        push_tx(8'hA1);
        push_tx(8'hA2);
        push_tx(8'hA3);
        wlog.delete();
        blog.delete();
        for (int i = 0; i < 8; i++) host_bytes[i] = 8'(8'h71 + i);
        host_idx = 0;
        host_n   = 8;
        ft_txe_n = 1'b0;
        repeat (25) cycle();
        check("arb_first_rx_bytes", 32'(host_idx), 32'd4);
        ft_txe_n = 1'b1;
        push_tx(8'hB1);
        push_tx(8'hB2);
        push_tx(8'hB3);
        rx_ready = 1'b1;
        cycle();
        rx_ready = 1'b0;
        ft_txe_n = 1'b0;
        repeat (20) cycle();
        check("arb_rx_bytes", 32'(host_idx), 32'd5);
        check("arb_blog_size", 32'(blog.size()), 32'd4);
        exp_b[0] = 8'h52;
        exp_b[1] = 8'h57;
        exp_b[2] = 8'h52;
        exp_b[3] = 8'h57;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("arb_order%0d", i), (i < blog.size()) ? blog[i] : 8'hxx, exp_b[i]);
        end
        exp_w[0] = 8'hA1;
        exp_w[1] = 8'hA2;
        exp_w[2] = 8'hA3;
        exp_w[3] = 8'hB1;
        exp_w[4] = 8'hB2;
        exp_w[5] = 8'hB3;
        check("arb_wlog_size", 32'(wlog.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("arb_wlog%0d", i), (i < wlog.size()) ? wlog[i] : 8'hxx, exp_w[i]);
        end

        // ---- Asynchronous reset while reading
        rx_ready = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (!ft_rd_n) begin
                hit = 1'b1;
                break;
            end
        end
        check("reached_rx_read", 32'(hit), 32'd1);
        #1 rst_n = 1'b0;
        #1 check("reset_in_rx_read", 32'(outs()), 32'(ResetExp));
        host_n = host_idx;
        @(negedge clk_in);
        rst_n = 1'b1;
        repeat (3) cycle();
        check("idle_after_rx_reset", {ft_oe_n, ft_rd_n, ft_wr_n, ft_siwu_n, ft_data_oe, rx_valid},
              6'b111100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d/%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
